// File: rtl/mlp_multi_neuron.sv
// Time-multiplexed MLP engine: P MAC lanes sweep every layer of an N-wide network.
// Weights/biases sit in unreset register storage; x and y use valid/ready handshakes.

module mlp_multi_neuron #(
    parameter int M    = 3,
    parameter int N    = 4,
    parameter int P    = 2,
    parameter int QM   = 3,
    parameter int QN   = 5,
    parameter int WM   = 3,
    parameter int WN   = 5,
    parameter int RELU = 1,
    localparam int AW  = QM + QN,
    localparam int WW  = WM + WN,
    localparam int LYW = (M > 2) ? $clog2(M - 1) : 1,
    localparam int NW  = (N > 1) ? $clog2(N) : 1,
    localparam int IW  = $clog2(N + 1)
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        wr_en,
    input  logic [LYW-1:0]              wr_layer,
    input  logic [NW-1:0]               wr_neuron,
    input  logic [IW-1:0]               wr_idx,
    input  logic signed [WW-1:0]        wr_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [N-1:0][AW-1:0] x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [N-1:0][AW-1:0] y,
    output logic                        busy
);
    localparam int GW   = (N / P > 1) ? $clog2(N / P) : 1;
    localparam int ACCW = AW + WW + IW;

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t               state_q, state_d;
    logic [LYW-1:0]       layer_q, layer_d;
    logic [GW-1:0]        grp_q, grp_d;
    logic [NW-1:0]        k_q, k_d;
    logic                 mac_en, first, last_grp, last_layer, wr_ok;
    logic [N-1:0][AW-1:0] cur_q, nxt_q, nxt_d, y_q;
    logic [P-1:0][AW-1:0] res;
    logic [P-1:0][NW-1:0] nidx;

    logic [WW-1:0] w_q [M-1][N][N];
    logic [WW-1:0] b_q [M-1][N];

    // Writes are locked out while lanes are reading storage.
    assign wr_ok = wr_en && (state_q == IDLE || state_q == DONE)
                 && (int'(wr_layer) < M - 1) && (int'(wr_neuron) < N) && (int'(wr_idx) <= N);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (int'(wr_idx) == N) b_q[wr_layer][wr_neuron] <= wr_data;
            else                   w_q[wr_layer][wr_neuron][NW'(wr_idx)] <= wr_data;
        end
    end

    assign last_grp   = (grp_q == GW'(N / P - 1));
    assign last_layer = (layer_q == LYW'(M - 2));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            layer_q <= '0;
            grp_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            grp_q   <= grp_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        grp_d   = grp_q;
        k_d     = k_q;
        mac_en  = 1'b0;
        first   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = MAC;
                layer_d = '0;
                grp_d   = '0;
                k_d     = '0;
            end
            MAC: begin
                mac_en = 1'b1;
                first  = (k_q == '0);
                if (k_q == NW'(N - 1)) begin
                    state_d = WB;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            WB: begin
                k_d = '0;
                if (!last_grp) begin
                    grp_d   = grp_q + 1'b1;
                    state_d = MAC;
                end else begin
                    grp_d = '0;
                    if (last_layer) begin
                        state_d = DONE;
                    end else begin
                        layer_d = layer_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        assign nidx[p] = NW'(int'(grp_q) * P + p);
        mlp_mac_lane #(
            .AW(AW), .WW(WW), .QN(QN), .WN(WN), .ACCW(ACCW), .RELU(RELU)
        ) u_lane (
            .clk    (clk),
            .nrst   (nrst),
            .en_i   (mac_en),
            .first_i(first),
            .x_i    (cur_q[k_q]),
            .w_i    (w_q[layer_q][nidx[p]][k_q]),
            .b_i    (b_q[layer_q][nidx[p]]),
            .res_o  (res[p])
        );
    end

    always_comb begin
        nxt_d = nxt_q;
        for (int p = 0; p < P; p++) nxt_d[nidx[p]] = res[p];
    end

    // Groups of a layer still read cur_q, so results collect in nxt_q until the layer ends.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur_q <= '0;
            nxt_q <= '0;
            y_q   <= '0;
        end else if (state_q == IDLE && in_valid) begin
            cur_q <= x;
        end else if (state_q == WB) begin
            nxt_q <= nxt_d;
            if (last_grp) begin
                cur_q <= nxt_d;
                if (last_layer) y_q <= nxt_d;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MAC) || (state_q == WB);
    assign y         = y_q;

endmodule

// One MAC lane: accumulates x*w over a group, then floors, saturates and rectifies.
module mlp_mac_lane #(
    parameter int AW   = 8,
    parameter int WW   = 8,
    parameter int QN   = 5,
    parameter int WN   = 5,
    parameter int ACCW = 19,
    parameter int RELU = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en_i,
    input  logic                 first_i,
    input  logic signed [AW-1:0] x_i,
    input  logic signed [WW-1:0] w_i,
    input  logic signed [WW-1:0] b_i,
    output logic        [AW-1:0] res_o
);
    localparam logic [AW-1:0] SMAX_A = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN_A = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [ACCW-1:0] SMAX = ACCW'(SMAX_A);
    localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

    logic signed [ACCW-1:0] acc_q, acc_d, prod, sh;

    assign prod  = ACCW'(x_i) * ACCW'(w_i);
    // Bias carries WN fraction bits; shifting by QN aligns it with the product scale.
    assign acc_d = first_i ? (ACCW'(b_i) <<< QN) + prod : acc_q + prod;
    assign sh    = acc_q >>> WN;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)     acc_q <= '0;
        else if (en_i) acc_q <= acc_d;
    end

    always_comb begin
        res_o = sh[AW-1:0];
        if (sh > SMAX)      res_o = SMAX_A;
        else if (sh < SMIN) res_o = SMIN_A;
        if (RELU != 0 && res_o[AW-1]) res_o = '0;
    end

endmodule

// File: tb/tb_mlp_multi_neuron.sv
// Bench for mlp_multi_neuron: a linear and a ReLU instance share stimulus and are
// checked against an integer reference of the layer equations.

module tb_mlp_multi_neuron;
    localparam int M = 3, N = 4, P = 2, QM = 3, QN = 5, WM = 3, WN = 5;
    localparam int AW = QM + QN;
    localparam int LAT = (M - 1) * (N / P) * (N + 1) + 1;
    localparam int AMAX = (1 << (AW - 1)) - 1;
    localparam int AMIN = -(1 << (AW - 1));

    logic clk = 1'b0, nrst = 1'b0, wr_en = 1'b0;
    logic [0:0] wr_layer = '0;
    logic [1:0] wr_neuron = '0;
    logic [2:0] wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic [N-1:0][AW-1:0] x = '0;
    logic in_ready_l, out_valid_l, busy_l, in_ready_r, out_valid_r, busy_r;
    logic [N-1:0][AW-1:0] y_l, y_r;

    int W [M-1][N][N];
    int B [M-1][N];
    int xv [N];
    int expy [2][N];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mlp_multi_neuron #(.M(M), .N(N), .P(P), .QM(QM), .QN(QN), .WM(WM), .WN(WN), .RELU(0)) u_lin (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_layer(wr_layer), .wr_neuron(wr_neuron),
        .wr_idx(wr_idx), .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready_l), .x(x),
        .out_valid(out_valid_l), .out_ready(out_ready), .y(y_l), .busy(busy_l));

    mlp_multi_neuron #(.M(M), .N(N), .P(P), .QM(QM), .QN(QN), .WM(WM), .WN(WN), .RELU(1)) u_relu (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_layer(wr_layer), .wr_neuron(wr_neuron),
        .wr_idx(wr_idx), .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready_r), .x(x),
        .out_valid(out_valid_r), .out_ready(out_ready), .y(y_r), .busy(busy_r));

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_y(input string tag);
        for (int n = 0; n < N; n++) begin
            check($sformatf("%s lin y[%0d]", tag, n), $signed(y_l[n]), expy[0][n]);
            check($sformatf("%s relu y[%0d]", tag, n), $signed(y_r[n]), expy[1][n]);
        end
    endtask

    // Reference: y = clamp(floor((b*2^QN + sum x*w) / 2^WN)), optional ReLU, per layer.
    task automatic compute_model();
        int a [N];
        int b [N];
        int s, v;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) a[i] = xv[i];
            for (int l = 0; l < M - 1; l++) begin
                for (int n = 0; n < N; n++) begin
                    s = B[l][n] * (1 << QN);
                    for (int k = 0; k < N; k++) s += a[k] * W[l][n][k];
                    v = s >>> WN;
                    if (v > AMAX) v = AMAX;
                    if (v < AMIN) v = AMIN;
                    if (r == 1 && v < 0) v = 0;
                    b[n] = v;
                end
                for (int i = 0; i < N; i++) a[i] = b[i];
            end
            for (int i = 0; i < N; i++) expy[r][i] = a[i];
        end
    endtask

    task automatic arm_wr(input int l, input int n, input int i, input int d);
        wr_en = 1'b1; wr_layer = 1'(l); wr_neuron = 2'(n); wr_idx = 3'(i); wr_data = 8'(d);
        if (l < M - 1 && n < N && i <= N) begin
            if (i == N) B[l][n] = d;
            else        W[l][n][i] = d;
        end
    endtask

    task automatic wr(input int l, input int n, input int i, input int d);
        arm_wr(l, n, i, d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_identity();
        for (int l = 0; l < M - 1; l++)
            for (int n = 0; n < N; n++)
                for (int i = 0; i <= N; i++) wr(l, n, i, (i == n) ? 32 : 0);
    endtask

    task automatic load_const(input int wv);
        for (int l = 0; l < M - 1; l++)
            for (int n = 0; n < N; n++)
                for (int i = 0; i <= N; i++) wr(l, n, i, (i == N) ? 0 : wv);
    endtask

    task automatic load_random();
        for (int l = 0; l < M - 1; l++)
            for (int n = 0; n < N; n++)
                for (int i = 0; i <= N; i++)
                    wr(l, n, i, (i == N) ? int'($urandom_range(0, 127)) - 64
                                         : int'($urandom_range(0, 95)) - 48);
    endtask

    // Called at a negedge with the engine idle; mac_wr > 0 injects a write at that cycle.
    task automatic run(input string tag, input int mac_wr);
        int cnt;
        compute_model();
        for (int i = 0; i < N; i++) x[i] = 8'(xv[i]);
        in_valid = 1'b1;
        @(posedge clk);
        cnt = 1;
        #1 in_valid = 1'b0;
        wr_en = 1'b0;
        check({tag, " busy"}, busy_l, 1);
        while (!out_valid_l && cnt < 200) begin
            if (cnt == mac_wr) begin
                wr_en = 1'b1; wr_layer = 1'b0; wr_neuron = 2'd0; wr_idx = 3'd0; wr_data = 8'h9c;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk);
            cnt++;
            #1;
        end
        wr_en = 1'b0;
        check({tag, " latency"}, cnt, LAT);
        check({tag, " relu out_valid"}, out_valid_r, 1);
        check({tag, " in_ready in done"}, in_ready_l, 0);
        check_y(tag);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, " back to idle"}, in_ready_l, 1);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1 reset
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("t1 in_ready", in_ready_l, 1);
        check("t1 out_valid", out_valid_l, 0);
        check("t1 busy", busy_l, 0);
        check("t1 y lin", $signed(y_l), 0);
        check("t1 y relu", $signed(y_r), 0);

        // T2/T3 identity network
        load_identity();
        xv = '{32, -16, 64, 8};
        run("t2", 0);
        check("t2 lin y1 const", $signed(y_l[1]), -16);
        check("t3 relu y1 const", $signed(y_r[1]), 0);
        check("t3 relu y2 const", $signed(y_r[2]), 64);

        // Out-of-range index writes must not land anywhere
        wr(0, 0, 5, -100);
        wr(1, 2, 7, 55);
        run("idx oob", 0);

        // Write and accept in the same cycle: new bias is used
        arm_wr(0, 1, N, 48);
        run("wr+accept", 0);

        // T4 saturation
        load_const(96);
        xv = '{96, 96, 96, 96};
        run("t4 pos", 0);
        check("t4 relu sat const", $signed(y_r[3]), 127);
        load_const(-96);
        run("t4 neg", 0);
        check("t4 relu zero const", $signed(y_r[0]), 0);

        // T5 backpressure in DONE
        load_identity();
        xv = '{32, -16, 64, 8};
        out_ready = 1'b0;
        run("t5", 0);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t5 hold out_valid c%0d", c), out_valid_l, 1);
            check($sformatf("t5 hold in_ready c%0d", c), in_ready_l, 0);
            check($sformatf("t5 hold y0 c%0d", c), $signed(y_l[0]), expy[0][0]);
            check($sformatf("t5 hold y1 c%0d", c), $signed(y_l[1]), expy[0][1]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5 release in_ready", in_ready_l, 1);
        check("t5 release out_valid", out_valid_l, 0);
        @(negedge clk);

        // T6 abort mid-MAC, then rerun without reload
        for (int i = 0; i < N; i++) x[i] = 8'(xv[i]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6 busy before abort", busy_l, 1);
        nrst = 1'b0;
        #1;
        check("t6 abort in_ready", in_ready_l, 1);
        check("t6 abort out_valid", out_valid_r, 0);
        check("t6 abort busy", busy_r, 0);
        check("t6 abort y lin", $signed(y_l), 0);
        check("t6 abort y relu", $signed(y_r), 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        run("t6 rerun", 0);
        run("t6 mac write", 3);
        run("t6 after mac write", 0);

        // Randomized networks and inputs
        for (int t = 0; t < 5; t++) begin
            load_random();
            for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
            run($sformatf("rand%0d", t), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
